// File: rtl/mag_cmp_arb_pkg.sv
// Shared definitions for the magnitude-compare arbiter.
// Holds the requester count, operand width, FSM encodings and the round-robin pick helper.
package mag_cmp_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMP  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Requester 0 gets the first grant after reset.
  localparam logic [ID_W-1:0] RESET_LAST_GRANT = 2'd3;

  // Round-robin pick: search upward from (last + 1) with wrap, first set request wins.
  // Result is don't-care when no request is set; the caller qualifies it with |req.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
    to_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mag_cmp_arb_mag_comp4.sv
// magComp4: 4-bit unsigned magnitude comparator.
// Exactly one of eq / a_gt / b_gt is high for any input pair.
module magComp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       a_gt,
  output logic       b_gt
);

  assign eq   = (a == b);
  assign a_gt = (a > b);
  assign b_gt = (b > a);

endmodule

// File: rtl/mag_cmp_arb.sv
// mag_cmp_arb: round-robin arbiter in front of a single 4-bit magnitude comparator.
// IDLE grants and captures operands, CMP registers the compare result,
// RESP holds the result until the consumer accepts it.
module mag_cmp_arb
  import mag_cmp_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*OP_W-1:0] opA,
  input  logic [NUM_REQ*OP_W-1:0] opB,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [ID_W-1:0]         rspId,
  output logic                    rspEq,
  output logic                    rspAGt,
  output logic                    rspBGt,
  output logic                    busy
);

  state_t              state_r;
  state_t              next_state_s;
  logic [ID_W-1:0]     last_grant_r;
  logic [ID_W-1:0]     grant_s;
  logic                req_any_s;
  logic [OP_W-1:0]     op_reg_a_r;
  logic [OP_W-1:0]     op_reg_b_r;
  logic                cmp_eq_s;
  logic                cmp_a_gt_s;
  logic                cmp_b_gt_s;

  logic [NUM_REQ-1:0]  ack_r;
  logic                rsp_valid_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic                rsp_eq_r;
  logic                rsp_a_gt_r;
  logic                rsp_b_gt_r;
  logic                busy_r;

  logic [NUM_REQ-1:0]  ack_nxt_s;
  logic                rsp_valid_nxt_s;
  logic [ID_W-1:0]     rsp_id_nxt_s;
  logic                rsp_eq_nxt_s;
  logic                rsp_a_gt_nxt_s;
  logic                rsp_b_gt_nxt_s;
  logic [OP_W-1:0]     op_a_nxt_s;
  logic [OP_W-1:0]     op_b_nxt_s;
  logic [ID_W-1:0]     last_grant_nxt_s;
  logic                busy_nxt_s;

  assign req_any_s = |req;
  assign grant_s   = rr_pick(req, last_grant_r);

  // The only comparison logic: one comparator on the captured operands.
  magComp4 u_mag_comp4 (
    .a    (op_reg_a_r),
    .b    (op_reg_b_r),
    .eq   (cmp_eq_s),
    .a_gt (cmp_a_gt_s),
    .b_gt (cmp_b_gt_s)
  );

  // State register; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          next_state_s = ST_CMP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CMP: begin
        next_state_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_r && rspReady) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and datapath; everything holds unless the state acts on it.
  always_comb begin
    ack_nxt_s        = '0;
    rsp_valid_nxt_s  = rsp_valid_r;
    rsp_id_nxt_s     = rsp_id_r;
    rsp_eq_nxt_s     = rsp_eq_r;
    rsp_a_gt_nxt_s   = rsp_a_gt_r;
    rsp_b_gt_nxt_s   = rsp_b_gt_r;
    op_a_nxt_s       = op_reg_a_r;
    op_b_nxt_s       = op_reg_b_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          op_a_nxt_s       = opA[{grant_s, 2'b00} +: OP_W];
          op_b_nxt_s       = opB[{grant_s, 2'b00} +: OP_W];
          ack_nxt_s        = to_onehot(grant_s);
          last_grant_nxt_s = grant_s;
          rsp_id_nxt_s     = grant_s;
        end else begin
          ack_nxt_s = '0;
        end
      end
      ST_CMP: begin
        rsp_eq_nxt_s    = cmp_eq_s;
        rsp_a_gt_nxt_s  = cmp_a_gt_s;
        rsp_b_gt_nxt_s  = cmp_b_gt_s;
        rsp_valid_nxt_s = 1'b1;
      end
      ST_RESP: begin
        if (rsp_valid_r && rspReady) begin
          rsp_valid_nxt_s = 1'b0;
        end else begin
          rsp_valid_nxt_s = rsp_valid_r;
        end
      end
      default: begin
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (next_state_s != ST_IDLE);
  end

  // Output and datapath registers; reset clears everything and rearms requester 0 as first grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r        <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_eq_r     <= 1'b0;
      rsp_a_gt_r   <= 1'b0;
      rsp_b_gt_r   <= 1'b0;
      op_reg_a_r   <= '0;
      op_reg_b_r   <= '0;
      last_grant_r <= RESET_LAST_GRANT;
      busy_r       <= 1'b0;
    end else begin
      ack_r        <= ack_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rsp_id_r     <= rsp_id_nxt_s;
      rsp_eq_r     <= rsp_eq_nxt_s;
      rsp_a_gt_r   <= rsp_a_gt_nxt_s;
      rsp_b_gt_r   <= rsp_b_gt_nxt_s;
      op_reg_a_r   <= op_a_nxt_s;
      op_reg_b_r   <= op_b_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign ack      = ack_r;
  assign rspValid = rsp_valid_r;
  assign rspId    = rsp_id_r;
  assign rspEq    = rsp_eq_r;
  assign rspAGt   = rsp_a_gt_r;
  assign rspBGt   = rsp_b_gt_r;
  assign busy     = busy_r;

endmodule
